// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver.
// Data width, parity mode and stop-bit count are fixed at elaboration; the
// baud divisor is latched from i_div at each start bit (minimum 4).
// A two-flop synchroniser guards the asynchronous line. Parity and framing
// errors travel with each word through a valid/ready holding register, and a
// frame that arrives while the register is still full is dropped with a
// one-cycle o_overrun pulse. A line held low past a bad stop bit is treated
// as a break and yields exactly one frame.
module uart_rx_cfg #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_dat,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]     LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]     LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV   = DIV_WIDTH'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BRK
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, rx_s_q;
    logic [DIV_WIDTH-1:0] div_l_q, div_l_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic [DATA_BITS-1:0] dat_q, dat_d;
    logic                 hold_fe_q, hold_fe_d;
    logic                 hold_pe_q, hold_pe_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;

    logic                 sample;
    logic                 stop_err;

    // The single mid-bit sample point; the counter phase is fixed at start entry.
    assign sample = (cnt_q == (div_l_q >> 1));

    // State, synchroniser, bit timing and holding register.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // sees the pre-edge values of the others, independent of statement order.
        if (i_reset) begin
            // NOTE: the datapath registers are reset along with the control state,
            // so the word and flags read 0 after reset rather than X.
            state_q   <= S_IDLE;
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            div_l_q   <= MIN_DIV;
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            dat_q     <= '0;
            hold_fe_q <= 1'b0;
            hold_pe_q <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= i_rx;
            rx_s_q    <= sync1_q;
            div_l_q   <= div_l_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            dat_q     <= dat_d;
            hold_fe_q <= hold_fe_d;
            hold_pe_q <= hold_pe_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state: frame sequencing, bit capture, error checks and handoff.
    always_comb begin
        // NOTE: every signal written here gets its default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        div_l_d   = div_l_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        dat_d     = dat_q;
        hold_fe_d = hold_fe_q;
        hold_pe_d = hold_pe_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        stop_err  = 1'b0;

        // Consumer handshake; a frame completing this cycle overrides below.
        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        // Free-running bit-period counter while a frame is in progress.
        if (cnt_q == div_l_q - DIV_WIDTH'(1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d   = S_START;
                    div_l_d   = (i_div < MIN_DIV) ? MIN_DIV : i_div;
                    idx_d     = '0;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end
            S_START: begin
                if (sample) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (sample) begin
                    shreg_d[idx_q] = rx_s_q;
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PAR: begin
                if (sample) begin
                    // Odd mode wants an odd count of ones over data plus parity.
                    if (PARITY == 1) begin
                        par_err_d = ~(^shreg_q ^ rx_s_q);
                    end else begin
                        par_err_d = ^shreg_q ^ rx_s_q;
                    end
                    idx_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    stop_err  = frm_err_q | ~rx_s_q;
                    frm_err_d = stop_err;
                    if (idx_q == LAST_STOP) begin
                        if (!valid_q || i_ready) begin
                            dat_d     = shreg_q;
                            hold_fe_d = stop_err;
                            hold_pe_d = par_err_q;
                            valid_d   = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                        // A line still low after a bad stop is a break: wait it out.
                        state_d = (stop_err && !rx_s_q) ? S_BRK : S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_BRK: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_dat        = dat_q;
    assign o_frame_err  = hold_fe_q;
    assign o_parity_err = hold_pe_q;
    assign o_valid      = valid_q;
    assign o_overrun    = overrun_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Configurable UART receiver. It is the parametrised successor to the fixed 8N1 receiver in the UART master path. Data width, parity mode and stop-bit count are set at elaboration, and the baud divisor is a run-time input. It adds an input synchroniser, parity and framing error detection, a valid/ready holding register with overrun reporting, and break handling.

## Interface
- DATA_BITS, 8: data bits per frame, legal 5..9, LSB first on the line.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- DIV_WIDTH, 16: width of the baud divisor.
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_div  in  DIV_WIDTH  clocks per bit; latched on start detection; values < 4 treated as 4.
- i_rx  in  1  asynchronous serial line, idle high.
- o_dat  out  DATA_BITS  received word, valid while o_valid.
- o_frame_err  out  1  stop bit(s) sampled low for the held word; qualified by o_valid.
- o_parity_err  out  1  parity mismatch for the held word; qualified by o_valid; always 0 when PARITY=0.
- o_valid  out  1  holding register full.
- i_ready  in  1  consumer accepts the word when o_valid && i_ready.
- o_overrun  out  1  one-cycle pulse: a completed frame was dropped.
- o_busy  out  1  state != IDLE.

## Operation
- Synchroniser: two flops on i_rx, reset value 1. All logic uses the synchronised value rx_s.
- Bit counter cnt runs 0..div_l-1 and wraps. It is cleared on entry to START. Sample point: cnt == div_l>>1 (integer).
- States: IDLE, START, DATA, PAR, STOP, BRK.
- IDLE: rx_s==0 → START; latch div_l = max(i_div,4); cnt=0.
- START: at sample, rx_s==1 → IDLE (glitch, nothing reported); else → DATA with bit index 0.
- DATA: at each sample, shift rx_s into bit [idx]. After DATA_BITS samples → PAR if PARITY!=0, else STOP.
- PAR: at sample, compute the error. Odd mode: XOR(data, parity bit) must be 1. Even mode: it must be 0.
- STOP: sample STOP_BITS times, one bit period apart. A frame error is any stop sample == 0.
- At the final stop sample the frame completes:
  - If o_valid==0, or o_valid && i_ready that cycle: load o_dat and both error flags, and set o_valid=1.
  - Else: pulse o_overrun. The held word is unchanged and the new frame is discarded.
- After completion: frame error with rx_s==0 → BRK; otherwise → IDLE. This lets a back-to-back start bit beginning right after the stop sample point be caught.
- BRK: wait for rx_s==1, then → IDLE. A held-low line produces exactly one frame (with frame error), not repeated frames.
- Holding register:
  - o_valid clears on o_valid && i_ready unless a new frame loads in the same cycle.
  - o_dat and the flags are stable while o_valid=1.
- i_div changes mid-frame have no effect until the next start.
- Reset values: o_valid 0, o_dat 0, o_frame_err 0, o_parity_err 0, o_overrun 0, o_busy 0, state IDLE, synchroniser flops 1.
- Reset mid-frame aborts the frame with no delivery and no overrun.

## Timing
- i_rx falling edge to START entry: 3 cycles (2 synchroniser + 1 IDLE decision). Call the START entry cycle t0.
- Bit k sample cycle (k=0 start, 1..DATA_BITS data, then parity, then stops): t0 + k·div_l + (div_l>>1).
- o_valid rises, or o_overrun pulses, the cycle after the final stop sample.
- Frame-to-o_valid latency for 8N1 at div=16: t0 + 9·16 + 8 + 1 = t0+153.
- o_busy is high from t0 until the cycle after returning to IDLE.
- Handshake: transfer happens on a cycle with o_valid && i_ready. i_ready has no combinational path to o_dat.

## Test plan
- 8N1, i_div=16, send 0xA5, i_ready=1: o_dat=0xA5 and o_valid high for 1 cycle at t0+153; both error flags 0.
- 3-cycle low glitch on i_rx: no o_valid; o_busy high about 9 cycles, then 0; the next real frame 0x5A is received correctly.
- PARITY=2, DATA_BITS=7, send 0x3C with parity bit 1 (wrong): o_dat=0x3C, o_parity_err=1. Same frame with parity 0: o_parity_err=0.
- Stop bit driven 0, then line held low 200 cycles, then high, then frame 0x81:
  - exactly one frame with o_frame_err=1;
  - no second frame during the low period;
  - then 0x81 with no errors.
- i_ready=0, frames 0x11 then 0x22 back to back: o_dat stays 0x11 with o_valid=1; o_overrun pulses once, 1 cycle after the 0x22 stop sample. With i_ready asserted in that completion cycle, 0x22 loads instead and no overrun occurs.
- i_reset asserted mid-data of frame 0xFF:
  - all outputs 0 the next cycle, with no delivery;
  - STOP_BITS=2, i_div=7 (div>>1=3) frame 0x42 afterwards is received correctly;
  - a stop-2 low sample gives o_frame_err=1.
